// File: rtl/sar_adc_controller_if.sv
// Handshake and data bundle between the SAR controller and its environment:
// control requests and comparator in, trial code and conversion result out.
interface sar_adc_controller_if #(
   parameter int WIDTH = 8
) ();
   logic             enable;
   logic             start;
   logic             continuous;
   logic             comp_in;
   logic [WIDTH-1:0] dac_code;
   logic             busy;
   logic [WIDTH-1:0] result;
   logic             result_valid;

   // Environment side: issues requests, supplies the comparator decision.
   modport master (
      output enable, start, continuous, comp_in,
      input  dac_code, busy, result, result_valid
   );

   // Controller side.
   modport slave (
      input  enable, start, continuous, comp_in,
      output dac_code, busy, result, result_valid
   );
endinterface

// File: rtl/sar_adc_controller.sv
// Successive-approximation controller: drives an MSB-first trial code into the
// DAC path, waits SETTLE_CYCLES per bit for the RC filter, then resolves the
// bit from the synchronized comparator output.
module sar_adc_controller #(
   parameter int WIDTH         = 8,
   parameter int SETTLE_CYCLES = 4,
   parameter int SYNC_STAGES   = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   sar_adc_controller_if.slave  bus
);
   localparam int IDX_W = $clog2(WIDTH);
   localparam int CNT_W = $clog2(SETTLE_CYCLES);
   localparam logic [IDX_W-1:0] IDX_MAX   = IDX_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [WIDTH-1:0] MSB_TRIAL = {1'b1, {(WIDTH-1){1'b0}}};

   // The comparator must be stable through the synchronizer before the
   // decision edge, so the settle interval has to outlast it.
   if (WIDTH < 2) begin : g_chk_width
      $error("WIDTH must be >= 2");
   end
   if (SYNC_STAGES < 2) begin : g_chk_sync
      $error("SYNC_STAGES must be >= 2");
   end
   if (SETTLE_CYCLES <= SYNC_STAGES) begin : g_chk_settle
      $error("SETTLE_CYCLES must be greater than SYNC_STAGES");
   end

   typedef enum logic {
      IDLE = 1'b0,
      CONV = 1'b1
   } state_t;

   state_t                 state_q, state_d;
   logic [WIDTH-1:0]       dac_code_q, dac_code_d;
   logic [WIDTH-1:0]       result_q, result_d;
   logic                   result_valid_q, result_valid_d;
   logic [IDX_W-1:0]       bit_idx_q, bit_idx_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   comp_s;
   logic [WIDTH-1:0]       trial;

   // Synchronizer chain: stage 0 takes the raw comparator, each later stage
   // takes its predecessor.
   for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
         assign sync_d[gi] = bus.comp_in;
      end else begin : g_rest
         assign sync_d[gi] = sync_q[gi-1];
      end
   end
   assign comp_s = sync_q[SYNC_STAGES-1];

   // State register and all datapath flops; reset clears everything.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= IDLE;
         dac_code_q     <= '0;
         result_q       <= '0;
         result_valid_q <= 1'b0;
         bit_idx_q      <= '0;
         cnt_q          <= '0;
         sync_q         <= '0;
      end else begin
         state_q        <= state_d;
         dac_code_q     <= dac_code_d;
         result_q       <= result_d;
         result_valid_q <= result_valid_d;
         bit_idx_q      <= bit_idx_d;
         cnt_q          <= cnt_d;
         sync_q         <= sync_d;
      end
   end

   // Next-state logic: launch, settle countdown, per-bit decision, abort.
   always_comb begin
      state_d        = state_q;
      dac_code_d     = dac_code_q;
      result_d       = result_q;
      result_valid_d = 1'b0;
      bit_idx_d      = bit_idx_q;
      cnt_d          = cnt_q;
      trial          = dac_code_q;

      case (state_q)
         IDLE: begin
            dac_code_d = result_q;
            if (bus.enable && (bus.start || bus.continuous)) begin
               state_d    = CONV;
               dac_code_d = MSB_TRIAL;
               bit_idx_d  = IDX_MAX;
               cnt_d      = CNT_MAX;
            end
         end
         CONV: begin
            if (!bus.enable) begin
               // Abort: fall back to the last good result, no strobe.
               state_d    = IDLE;
               dac_code_d = result_q;
            end else if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               trial[bit_idx_q] = comp_s;
               if (bit_idx_q != '0) begin
                  trial[bit_idx_q - IDX_W'(1)] = 1'b1;
                  bit_idx_d  = bit_idx_q - IDX_W'(1);
                  cnt_d      = CNT_MAX;
                  dac_code_d = trial;
               end else begin
                  result_d       = trial;
                  result_valid_d = 1'b1;
                  dac_code_d     = trial;
                  if (bus.continuous) begin
                     // Back-to-back conversion with no idle gap.
                     dac_code_d = MSB_TRIAL;
                     bit_idx_d  = IDX_MAX;
                     cnt_d      = CNT_MAX;
                  end else begin
                     state_d = IDLE;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.dac_code     = dac_code_q;
   assign bus.busy         = (state_q == CONV);
   assign bus.result       = result_q;
   assign bus.result_valid = result_valid_q;
endmodule

// File: tb/tb_sar_adc_controller.sv
// Directed bench for sar_adc_controller: a table of single conversions with
// hand-computed trial sequences, plus abort, continuous, ignored-start and
// mid-conversion reset sequences. Comparator model: comp_in = vin >= dac_code.
module tb_sar_adc_controller;
   logic       clk;
   logic       reset;
   logic [7:0] vin;
   int         n_checks;
   int         n_fail;

   sar_adc_controller_if #(.WIDTH(8)) sif ();

   sar_adc_controller #(
      .WIDTH        (8),
      .SETTLE_CYCLES(4),
      .SYNC_STAGES  (2)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (sif.slave)
   );

   assign sif.comp_in = (vin >= sif.dac_code);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]       vin;
      logic [7:0]       exp;
      logic [0:7][7:0]  trials;
   } vec_t;

   vec_t vecs [5];

   task automatic check1(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0b, expected %0b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%02h, expected 0x%02h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // One start-triggered conversion, checking every trial interval, the
   // strobe edge (32 edges after start) and the strobe's one-cycle width.
   task automatic run_conv(input vec_t t);
      @(negedge clk);
      vin       = t.vin;
      sif.start = 1'b1;
      for (int e = 0; e <= 33; e++) begin
         tick();
         if (e == 0) sif.start = 1'b0;
         if (e < 32) begin
            check1("busy_during", sif.busy, 1'b1);
            check1("valid_early", sif.result_valid, 1'b0);
            check8("dac_trial", sif.dac_code, t.trials[e/4]);
         end else if (e == 32) begin
            check1("valid_at_32", sif.result_valid, 1'b1);
            check8("result", sif.result, t.exp);
            check1("busy_fall", sif.busy, 1'b0);
            check8("dac_final", sif.dac_code, t.exp);
         end else begin
            check1("valid_one_cycle", sif.result_valid, 1'b0);
            check8("dac_idle", sif.dac_code, t.exp);
         end
      end
      $display("conv vin=0x%02h result=0x%02h expected=0x%02h", t.vin, sif.result, t.exp);
   endtask

   initial begin
      int strobes;
      n_checks       = 0;
      n_fail         = 0;
      vin            = 8'h00;
      reset          = 1'b1;
      sif.enable     = 1'b1;
      sif.start      = 1'b0;
      sif.continuous = 1'b0;

      vecs[0] = '{8'hA5, 8'hA5, {8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5}};
      vecs[1] = '{8'h00, 8'h00, {8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01}};
      vecs[2] = '{8'hFF, 8'hFF, {8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF}};
      vecs[3] = '{8'h80, 8'h80, {8'h80, 8'hC0, 8'hA0, 8'h90, 8'h88, 8'h84, 8'h82, 8'h81}};
      vecs[4] = '{8'h12, 8'h12, {8'h80, 8'h40, 8'h20, 8'h10, 8'h18, 8'h14, 8'h12, 8'h13}};

      repeat (3) tick();
      reset = 1'b0;
      check8("reset_dac", sif.dac_code, 8'h00);
      check8("reset_result", sif.result, 8'h00);
      check1("reset_busy", sif.busy, 1'b0);
      check1("reset_valid", sif.result_valid, 1'b0);
      $display("reset state checked");

      for (int i = 0; i < 5; i++) run_conv(vecs[i]);

      // Abort at cycle 10 with a prior result of 0x12.
      @(negedge clk);
      vin       = 8'h55;
      sif.start = 1'b1;
      strobes   = 0;
      for (int e = 0; e <= 50; e++) begin
         tick();
         if (e == 0) sif.start = 1'b0;
         if (e == 9) sif.enable = 1'b0;
         if (sif.result_valid) strobes++;
         if (e == 10) begin
            check1("abort_busy", sif.busy, 1'b0);
            check8("abort_dac", sif.dac_code, 8'h12);
            check8("abort_result", sif.result, 8'h12);
         end
      end
      check1("abort_no_strobe", strobes != 0, 1'b0);
      check8("abort_result_hold", sif.result, 8'h12);
      $display("abort vin=0x55 result=0x%02h strobes=%0d", sif.result, strobes);
      sif.enable = 1'b1;
      run_conv('{8'h55, 8'h55, {8'h80, 8'h40, 8'h60, 8'h50, 8'h58, 8'h54, 8'h56, 8'h55}});

      // Continuous mode: 0x3C then 0xC3, strobes every 32 edges, busy held.
      @(negedge clk);
      vin            = 8'h3C;
      sif.continuous = 1'b1;
      for (int e = 0; e <= 65; e++) begin
         tick();
         if (e == 33) vin = 8'hC3;
         if (e == 40) sif.continuous = 1'b0;
         if (e == 32) begin
            check1("cont_valid_1", sif.result_valid, 1'b1);
            check8("cont_result_1", sif.result, 8'h3C);
            check1("cont_busy_kept", sif.busy, 1'b1);
            check8("cont_restart_dac", sif.dac_code, 8'h80);
         end else if (e == 64) begin
            check1("cont_valid_2", sif.result_valid, 1'b1);
            check8("cont_result_2", sif.result, 8'hC3);
            check1("cont_busy_end", sif.busy, 1'b0);
         end else begin
            check1("cont_no_strobe", sif.result_valid, 1'b0);
            if (e < 64) check1("cont_busy", sif.busy, 1'b1);
         end
      end
      $display("continuous results 0x3C then 0x%02h", sif.result);

      // Start pulses at cycles 5 and 20 of a running conversion are ignored.
      @(negedge clk);
      vin       = 8'hA5;
      sif.start = 1'b1;
      strobes   = 0;
      for (int e = 0; e <= 70; e++) begin
         tick();
         sif.start = (e == 4) || (e == 19);
         if (sif.result_valid) strobes++;
         if (e == 32) begin
            check1("ign_valid_32", sif.result_valid, 1'b1);
            check8("ign_result", sif.result, 8'hA5);
         end else if (e > 32) begin
            check1("ign_idle", sif.busy, 1'b0);
         end
      end
      check1("ign_one_strobe", strobes == 1, 1'b1);
      $display("ignored start: strobes=%0d result=0x%02h", strobes, sif.result);

      // Reset at cycle 15 of a conversion.
      @(negedge clk);
      vin       = 8'h3C;
      sif.start = 1'b1;
      strobes   = 0;
      for (int e = 0; e <= 60; e++) begin
         tick();
         if (e == 0) sif.start = 1'b0;
         if (e == 14) reset = 1'b1;
         if (e == 15) begin
            reset = 1'b0;
            check8("rst_dac", sif.dac_code, 8'h00);
            check8("rst_result", sif.result, 8'h00);
            check1("rst_busy", sif.busy, 1'b0);
            check1("rst_valid", sif.result_valid, 1'b0);
         end
         if (e >= 15 && sif.result_valid) strobes++;
      end
      check1("rst_no_strobe", strobes != 0, 1'b0);
      check1("rst_idle", sif.busy, 1'b0);
      $display("reset mid-conversion: strobes after reset=%0d", strobes);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/sar_adc_controller.md
Name: sar_adc_controller

Overview:
- Successive-approximation controller that closes the loop around the PWM/R2R DAC path and external analog comparator.
- Drives an 8-bit trial code into the `current_reference` / `current_reference_r2r` inputs of `waveform_generator`.
- Samples the asynchronous comparator output after a programmable RC-settling interval and resolves one bit per interval, MSB first.
- Produces a registered conversion result with a one-cycle valid strobe for the display/averaging logic downstream.

Parameters:
- WIDTH, 8, resolution of trial code and result in bits; must be >= 2.
- SETTLE_CYCLES, 4, clock cycles the DAC/filter is given to settle per bit before the comparator is sampled; must be > SYNC_STAGES, else elaboration `$error`.
- SYNC_STAGES, 2, flip-flop stages in the `comp_in` synchronizer; must be >= 2.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- enable  input  1  active-high; low aborts any conversion and blocks new ones
- start  input  1  single-cycle request; begins a conversion when sampled in IDLE with enable=1
- continuous  input  1  when 1, a new conversion starts on the same edge the previous one completes
- comp_in  input  1  asynchronous comparator output; 1 = analog input >= DAC level
- dac_code  output  WIDTH  trial code to the DAC path
- busy  output  1  high while a conversion is in progress
- result  output  WIDTH  last completed conversion
- result_valid  output  1  one-cycle strobe on each completed conversion

Behaviour:
- **Reset:** clk, reset as already decided (reset synchronous, active-high; clock clk). Reset forces state=IDLE and dac_code=0, result=0, result_valid=0, busy=0. All synchronizer flops clear to 0. Reset overrides everything, including mid-conversion; no result_valid is produced.
- **Synchronizer:** `comp_in` passes through SYNC_STAGES flops; decisions use only the last stage (`comp_s`).
- **States:**
  - IDLE: busy=0; dac_code holds `result`.
  - CONV: busy=1.
- **Registers:** `bit_idx` (clog2(WIDTH) bits), settle counter `cnt` (clog2(SETTLE_CYCLES) bits), trial register.
- **IDLE -> CONV:** taken on an edge where enable=1 and (start=1 or continuous=1). On that edge:
  - dac_code <= 1<<(WIDTH-1)
  - bit_idx <= WIDTH-1
  - cnt <= SETTLE_CYCLES-1
- **In CONV, cnt != 0:** cnt decrements; dac_code is held.
- **In CONV, cnt == 0 (decision edge):**
  - bit[bit_idx] of dac_code is kept if comp_s=1, cleared if comp_s=0.
  - If bit_idx>0: set bit[bit_idx-1], bit_idx decrements, cnt reloads SETTLE_CYCLES-1.
  - If bit_idx==0: result <= final code (including this decision), result_valid <= 1 for exactly one cycle, dac_code <= final code.
    - If continuous=1 and enable=1: restart immediately, same as the IDLE->CONV edge (dac_code <= MSB trial, busy stays 1).
    - Otherwise go to IDLE.
- **Latency:** result_valid rises exactly WIDTH*SETTLE_CYCLES edges after the edge that sampled start. Default is 32 edges. In continuous mode results repeat every WIDTH*SETTLE_CYCLES cycles with no gap.
- **start while busy:** ignored; no queuing.
- **start and continuous both high:** behave identically to a single start.
- **enable=0 in CONV:** next edge goes to IDLE, busy=0, dac_code <= result (previous value), result unchanged, no result_valid. enable=0 in IDLE holds IDLE.
- **Code boundaries:**
  - All-ones input yields result = 2^WIDTH-1.
  - All-zeros input yields result = 0.
  - No overflow is possible; the trial register never exceeds WIDTH bits.
- **comp_in changing mid-bit:** only the synchronized value at the decision edge matters.

Test Plan:
All cases use WIDTH=8, SETTLE_CYCLES=4, SYNC_STAGES=2. The bench comparator model is comp_in = (vin >= dac_code), updated combinationally.
- **Nominal conversion:** vin=0xA5, one start pulse.
  - dac_code sequence is 0x80, 0xC0, 0xA0, 0xB0, 0xA8, 0xA4, 0xA6, 0xA5, each held 4 cycles.
  - result=0xA5 and result_valid=1 exactly 32 edges after start; busy falls the same edge.
- **Boundary codes:**
  - vin=0x00 -> result 0x00, with trials 0x80, 0x40, ..., 0x01.
  - vin=0xFF -> result 0xFF.
  - vin=0x80 -> result 0x80.
- **Continuous mode:** continuous=1, vin=0x3C, then vin=0xC3 during the second conversion's MSB interval.
  - Strobes occur every 32 cycles; busy never drops.
  - Results are 0x3C, then 0xC3.
- **Abort:** start with vin=0x55 after a prior result of 0x12; drop enable at cycle 10.
  - busy=0 next edge; dac_code=0x12; no result_valid; result stays 0x12.
  - A later start with enable=1 converts normally.
- **Reset mid-conversion:** assert reset at cycle 15 of a conversion.
  - Next edge: dac_code=0, result=0, busy=0, result_valid=0.
  - No strobe appears afterwards.
- **Ignored start:** pulse start at cycles 5 and 20 of a running conversion.
  - Exactly one result_valid is produced, at cycle 32.
  - No second conversion begins while continuous=0.
